// File: rtl/counter_sequencer.sv
// counter_sequencer
//   FSM controller for an external up/down counter. Runs single-shot
//   (start->end) or ping-pong (start->end->start) sequences for a requested
//   number of laps. It supports pause and abort, and reports busy/done/lap
//   progress back to the requester.
//
// Ports
//   iClk, iReset_n     clock, asynchronous active-low reset
//   iStart             command strobe, sampled only while idle
//   iMode              0 = single-shot, 1 = ping-pong
//   iStartValue        sequence start value
//   iEndValue          sequence end value
//   iLaps              laps to run (0 is treated as 1)
//   iPause             level, freezes counting while high
//   iAbort             terminates the running sequence (LOAD/RUN only)
//   iCount             external counter's current value
//   oClear             counter load strobe (loads oInitialValue)
//   oInitialValue      value loaded on oClear (latched start value)
//   oEnable            counter step enable
//   oUp_down           1 = count up, 0 = count down
//   oBusy              high in every state except idle
//   oDone              one-cycle pulse at normal completion
//   oLap               completed laps in the current sequence
module counter_sequencer #(
    parameter int WIDTH = 4,
    parameter int LAP_W = 4
) (
    input  logic             iClk,
    input  logic             iReset_n,
    input  logic             iStart,
    input  logic             iMode,
    input  logic [WIDTH-1:0] iStartValue,
    input  logic [WIDTH-1:0] iEndValue,
    input  logic [LAP_W-1:0] iLaps,
    input  logic             iPause,
    input  logic             iAbort,
    input  logic [WIDTH-1:0] iCount,
    output logic             oClear,
    output logic [WIDTH-1:0] oInitialValue,
    output logic             oEnable,
    output logic             oUp_down,
    output logic             oBusy,
    output logic             oDone,
    output logic [LAP_W-1:0] oLap
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] end_val;
    logic             mode;
    logic [LAP_W-1:0] laps;
    logic [LAP_W-1:0] lap;
    logic             phase;     // 0 = outbound (toward end), 1 = return

    logic             dir_up;
    logic [WIDTH-1:0] target;
    logic             at_target;
    logic [LAP_W-1:0] lap_next;
    logic             last_lap;

    // Direction is fixed for the whole sequence; the return leg inverts it.
    assign dir_up    = end_val > start_val;
    assign target    = phase ? start_val : end_val;
    assign at_target = (iCount == target);
    assign lap_next  = lap + 1'b1;
    assign last_lap  = (lap_next == laps);

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state     <= S_IDLE;
            start_val <= '0;
            end_val   <= '0;
            mode      <= 1'b0;
            laps      <= '0;
            lap       <= '0;
            phase     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // A start wins over a simultaneous abort here.
                    if (iStart) begin
                        start_val <= iStartValue;
                        end_val   <= iEndValue;
                        mode      <= iMode;
                        laps      <= (iLaps == '0) ? LAP_W'(1) : iLaps;
                        lap       <= '0;
                        phase     <= 1'b0;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state <= iAbort ? S_IDLE : S_RUN;
                end
                S_RUN: begin
                    if (iAbort) begin
                        state <= S_IDLE;
                    end else if (at_target) begin
                        if (!mode) begin
                            lap   <= lap_next;
                            state <= last_lap ? S_DONE : S_LOAD;
                        end else if (!phase) begin
                            phase <= 1'b1;
                        end else begin
                            // Counter already sits at start: next lap needs no reload.
                            phase <= 1'b0;
                            lap   <= lap_next;
                            if (last_lap) begin
                                state <= S_DONE;
                            end
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Abort suppresses the strobes in the very cycle it is seen.
    assign oClear        = (state == S_LOAD) && !iAbort;
    assign oEnable       = (state == S_RUN) && !iAbort && !iPause && !at_target;
    assign oUp_down      = phase ? ~dir_up : dir_up;
    assign oInitialValue = start_val;
    assign oBusy         = (state != S_IDLE);
    assign oDone         = (state == S_DONE);
    assign oLap          = lap;

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

    logic       iClk = 1'b0;
    logic       iReset_n;
    logic       iStart = 1'b0;
    logic       iMode = 1'b0;
    logic [3:0] iStartValue = '0;
    logic [3:0] iEndValue = '0;
    logic [3:0] iLaps = '0;
    logic       iPause = 1'b0;
    logic       iAbort = 1'b0;
    logic [3:0] iCount;
    logic       oClear;
    logic [3:0] oInitialValue;
    logic       oEnable;
    logic       oUp_down;
    logic       oBusy;
    logic       oDone;
    logic [3:0] oLap;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int clear_cnt = 0;
    int done_cnt = 0;
    logic [3:0] exp_init = '0;
    logic [3:0] cnt_model = '0;

    // Scoreboard: {count, direction} expected on every enabled step,
    // and the cycle number and lap value expected at each oDone.
    logic [4:0] en_q[$];
    int         done_cyc_q[$];
    logic [3:0] done_lap_q[$];

    counter_sequencer #(.WIDTH(4), .LAP_W(4)) dut (
        .iClk(iClk), .iReset_n(iReset_n), .iStart(iStart), .iMode(iMode),
        .iStartValue(iStartValue), .iEndValue(iEndValue), .iLaps(iLaps),
        .iPause(iPause), .iAbort(iAbort), .iCount(iCount),
        .oClear(oClear), .oInitialValue(oInitialValue), .oEnable(oEnable),
        .oUp_down(oUp_down), .oBusy(oBusy), .oDone(oDone), .oLap(oLap)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    // External 4-bit up/down counter.
    always @(posedge iClk) begin
        if (oClear) cnt_model <= oInitialValue;
        else if (oEnable) cnt_model <= oUp_down ? cnt_model + 4'd1 : cnt_model - 4'd1;
    end
    assign iCount = cnt_model;

    // Monitor: pops scoreboard entries as the DUT produces steps/done.
    initial begin
        logic [4:0] e;
        int c;
        logic [3:0] l;
        forever begin
            @(negedge iClk);
            if (oEnable) begin
                tests++;
                if (en_q.size() == 0) begin
                    fails++;
                    $display("FAIL step_unexpected: count=%0d up=%0d, no step expected", iCount, oUp_down);
                end else begin
                    e = en_q.pop_front();
                    if ({iCount, oUp_down} !== e) begin
                        fails++;
                        $display("FAIL step: count=%0d up=%0d, expected count=%0d up=%0d",
                                 iCount, oUp_down, e[4:1], e[0]);
                    end
                end
            end
            if (oClear) begin
                clear_cnt++;
                tests++;
                if (oInitialValue !== exp_init) begin
                    fails++;
                    $display("FAIL load_value: got %0d expected %0d", oInitialValue, exp_init);
                end
            end
            if (oDone) begin
                done_cnt++;
                tests++;
                if (done_cyc_q.size() == 0) begin
                    fails++;
                    $display("FAIL done_unexpected: oDone at cycle %0d", cyc);
                end else begin
                    c = done_cyc_q.pop_front();
                    l = done_lap_q.pop_front();
                    if (cyc !== c || oLap !== l) begin
                        fails++;
                        $display("FAIL done: cycle=%0d lap=%0d, expected cycle=%0d lap=%0d", cyc, oLap, c, l);
                    end
                end
            end
        end
    end

    task automatic start_seq(input logic [3:0] s, input logic [3:0] e, input logic m,
                             input logic [3:0] laps, input int extra,
                             input bit exp_done, input bit with_abort);
        int d;
        int nl;
        int t0;
        logic up;
        logic [3:0] v;
        @(posedge iClk); #1;
        t0 = cyc;
        up = (e > s);
        d  = up ? int'(e) - int'(s) : int'(s) - int'(e);
        nl = (laps == 0) ? 1 : int'(laps);
        for (int lp = 0; lp < nl; lp++) begin
            v = s;
            for (int k = 0; k < d; k++) begin
                en_q.push_back({v, up});
                v = up ? v + 4'd1 : v - 4'd1;
            end
            if (m) begin
                v = e;
                for (int k = 0; k < d; k++) begin
                    en_q.push_back({v, ~up});
                    v = up ? v - 4'd1 : v + 4'd1;
                end
            end
        end
        if (exp_done) begin
            done_cyc_q.push_back(t0 + extra + (m ? 2 + nl * (2 * d + 2) : nl * (d + 2) + 1));
            done_lap_q.push_back(4'(nl));
        end
        exp_init    = s;
        clear_cnt   = 0;
        iStartValue = s;
        iEndValue   = e;
        iMode       = m;
        iLaps       = laps;
        iAbort      = with_abort;
        iStart      = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        iAbort = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge iClk); #1;
            if (done_cyc_q.size() == 0) break;
        end
    endtask

    task automatic wait_count(input logic [3:0] v);
        for (int i = 0; i < 40; i++) begin
            @(posedge iClk); #1;
            if (iCount == v && oEnable) break;
        end
    endtask

    task automatic test_reset;
        iReset_n = 1'b1;
        #2 iReset_n = 1'b0;
        #1;
        tests++;
        if ({oClear, oInitialValue, oEnable, oUp_down, oBusy, oDone, oLap} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: clr=%0d init=%0d en=%0d ud=%0d busy=%0d done=%0d lap=%0d, expected all 0",
                     oClear, oInitialValue, oEnable, oUp_down, oBusy, oDone, oLap);
        end
        @(posedge iClk); #1;
        iReset_n = 1'b1;
    endtask

    task automatic test_single_up;
        start_seq(4'd2, 4'd5, 1'b0, 4'd1, 0, 1'b1, 1'b0);
        wait_done(60);
        tests++;
        if (done_cyc_q.size() != 0 || oBusy !== 1'b0 || oLap !== 4'd1) begin
            fails++;
            $display("FAIL single_up_end: pending=%0d busy=%0d lap=%0d, expected 0 0 1", done_cyc_q.size(), oBusy, oLap);
        end
        tests++;
        if (clear_cnt != 1 || en_q.size() != 0) begin
            fails++;
            $display("FAIL single_up_loads: loads=%0d left_steps=%0d, expected 1 0", clear_cnt, en_q.size());
        end
        done_cyc_q.delete(); done_lap_q.delete(); en_q.delete();
    endtask

    task automatic test_single_down_repeat;
        start_seq(4'd9, 4'd6, 1'b0, 4'd2, 0, 1'b1, 1'b0);
        repeat (3) @(posedge iClk);
        #1;
        // Start while busy: must be ignored.
        iStartValue = 4'd0; iEndValue = 4'd15; iMode = 1'b1; iLaps = 4'd7;
        iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        wait_done(60);
        tests++;
        if (done_cyc_q.size() != 0 || oBusy !== 1'b0 || oLap !== 4'd2) begin
            fails++;
            $display("FAIL down_repeat_end: pending=%0d busy=%0d lap=%0d, expected 0 0 2", done_cyc_q.size(), oBusy, oLap);
        end
        tests++;
        if (clear_cnt != 2 || en_q.size() != 0 || oInitialValue !== 4'd9) begin
            fails++;
            $display("FAIL down_repeat_loads: loads=%0d left_steps=%0d init=%0d, expected 2 0 9",
                     clear_cnt, en_q.size(), oInitialValue);
        end
        done_cyc_q.delete(); done_lap_q.delete(); en_q.delete();
    endtask

    task automatic test_ping_pong;
        start_seq(4'd3, 4'd5, 1'b1, 4'd1, 0, 1'b1, 1'b0);
        wait_done(60);
        tests++;
        if (done_cyc_q.size() != 0 || oLap !== 4'd1 || clear_cnt != 1 || en_q.size() != 0 || iCount !== 4'd3) begin
            fails++;
            $display("FAIL ping_pong_1: pending=%0d lap=%0d loads=%0d left=%0d count=%0d, expected 0 1 1 0 3",
                     done_cyc_q.size(), oLap, clear_cnt, en_q.size(), iCount);
        end
        done_cyc_q.delete(); done_lap_q.delete(); en_q.delete();
        start_seq(4'd6, 4'd4, 1'b1, 4'd2, 0, 1'b1, 1'b0);
        wait_done(60);
        tests++;
        if (done_cyc_q.size() != 0 || oLap !== 4'd2 || clear_cnt != 1 || en_q.size() != 0) begin
            fails++;
            $display("FAIL ping_pong_2: pending=%0d lap=%0d loads=%0d left=%0d, expected 0 2 1 0",
                     done_cyc_q.size(), oLap, clear_cnt, en_q.size());
        end
        done_cyc_q.delete(); done_lap_q.delete(); en_q.delete();
    endtask

    task automatic test_pause;
        start_seq(4'd0, 4'd8, 1'b0, 4'd1, 3, 1'b1, 1'b0);
        wait_count(4'd4);
        iPause = 1'b1;
        repeat (3) @(posedge iClk);
        #1;
        tests++;
        if (iCount !== 4'd4 || oBusy !== 1'b1 || oEnable !== 1'b0) begin
            fails++;
            $display("FAIL pause_hold: count=%0d busy=%0d en=%0d, expected 4 1 0", iCount, oBusy, oEnable);
        end
        iPause = 1'b0;
        wait_done(60);
        tests++;
        if (done_cyc_q.size() != 0 || oLap !== 4'd1 || en_q.size() != 0) begin
            fails++;
            $display("FAIL pause_end: pending=%0d lap=%0d left=%0d, expected 0 1 0", done_cyc_q.size(), oLap, en_q.size());
        end
        done_cyc_q.delete(); done_lap_q.delete(); en_q.delete();
    endtask

    task automatic test_abort;
        int dc;
        start_seq(4'd0, 4'd8, 1'b0, 4'd1, 0, 1'b0, 1'b0);
        wait_count(4'd6);
        iAbort = 1'b1;
        #1;
        tests++;
        if (oEnable !== 1'b0 || oClear !== 1'b0 || oBusy !== 1'b1) begin
            fails++;
            $display("FAIL abort_cycle: en=%0d clr=%0d busy=%0d, expected 0 0 1", oEnable, oClear, oBusy);
        end
        dc = done_cnt;
        @(posedge iClk); #1;
        iAbort = 1'b0;
        tests++;
        if (oBusy !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle: busy=%0d expected 0", oBusy);
        end
        en_q.delete();
        repeat (10) @(posedge iClk);
        #1;
        tests++;
        if (done_cnt != dc || oBusy !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_done: done pulses=%0d busy=%0d, expected 0 0", done_cnt - dc, oBusy);
        end
    endtask

    task automatic test_equal_corner;
        start_seq(4'd7, 4'd7, 1'b0, 4'd0, 0, 1'b1, 1'b0);
        wait_done(30);
        tests++;
        if (done_cyc_q.size() != 0 || oLap !== 4'd1 || clear_cnt != 1 || oBusy !== 1'b0) begin
            fails++;
            $display("FAIL equal_corner: pending=%0d lap=%0d loads=%0d busy=%0d, expected 0 1 1 0",
                     done_cyc_q.size(), oLap, clear_cnt, oBusy);
        end
        done_cyc_q.delete(); done_lap_q.delete(); en_q.delete();
    endtask

    task automatic test_back_to_back;
        // Start and abort together while idle: start is taken.
        start_seq(4'd1, 4'd3, 1'b0, 4'd1, 0, 1'b1, 1'b1);
        wait_done(30);
        tests++;
        if (done_cyc_q.size() != 0 || oLap !== 4'd1 || en_q.size() != 0) begin
            fails++;
            $display("FAIL start_with_abort: pending=%0d lap=%0d left=%0d, expected 0 1 0", done_cyc_q.size(), oLap, en_q.size());
        end
        done_cyc_q.delete(); done_lap_q.delete(); en_q.delete();
    endtask

    task automatic test_reset_mid_run;
        start_seq(4'd2, 4'd9, 1'b0, 4'd1, 0, 1'b0, 1'b0);
        wait_count(4'd5);
        #2 iReset_n = 1'b0;
        #1;
        tests++;
        if ({oClear, oInitialValue, oEnable, oUp_down, oBusy, oDone, oLap} !== '0) begin
            fails++;
            $display("FAIL reset_async: clr=%0d init=%0d en=%0d ud=%0d busy=%0d done=%0d lap=%0d, expected all 0",
                     oClear, oInitialValue, oEnable, oUp_down, oBusy, oDone, oLap);
        end
        en_q.delete();
        @(posedge iClk); #1;
        iReset_n = 1'b1;
        start_seq(4'd2, 4'd5, 1'b0, 4'd1, 0, 1'b1, 1'b0);
        tests++;
        if (oLap !== 4'd0 || oBusy !== 1'b1) begin
            fails++;
            $display("FAIL reset_fresh_start: lap=%0d busy=%0d, expected 0 1", oLap, oBusy);
        end
        wait_done(60);
        tests++;
        if (done_cyc_q.size() != 0 || oLap !== 4'd1 || en_q.size() != 0) begin
            fails++;
            $display("FAIL reset_fresh_end: pending=%0d lap=%0d left=%0d, expected 0 1 0", done_cyc_q.size(), oLap, en_q.size());
        end
        done_cyc_q.delete(); done_lap_q.delete(); en_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_up();
        test_single_down_repeat();
        test_ping_pong();
        test_pause();
        test_abort();
        test_equal_corner();
        test_back_to_back();
        test_reset_mid_run();
        repeat (2) @(posedge iClk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- FSM controller that drives the control pins of an external 4-bit up/down counter (clear/load, enable, direction, initial value) and watches its data output.
- Runs programmable count sequences: single-shot start->end, or ping-pong start->end->start, repeated N laps, with pause and abort.
- Sits between a software/switch command interface and the counter instance in the lab datapath; signals busy/done back to the requester.

Parameters:
- WIDTH, 4, counter data width (start/end/count/initial value).
- LAP_W, 4, width of lap-count request and lap counter.

Ports:
- iClk  input  1  system clock, all logic on rising edge
- iReset_n  input  1  asynchronous active-low reset
- iStart  input  1  command strobe; sampled only in IDLE
- iMode  input  1  0 = single-shot, 1 = ping-pong
- iStartValue  input  WIDTH  sequence start value
- iEndValue  input  WIDTH  sequence end value
- iLaps  input  LAP_W  laps to run; 0 treated as 1
- iPause  input  1  level; freezes counting while high
- iAbort  input  1  terminates the current sequence
- iCount  input  WIDTH  counter's current data output
- oClear  output  1  counter load strobe (loads oInitialValue)
- oInitialValue  output  WIDTH  value loaded on oClear
- oEnable  output  1  counter step enable
- oUp_down  output  1  1 = count up, 0 = count down
- oBusy  output  1  high in any state except IDLE
- oDone  output  1  one-cycle pulse at normal completion
- oLap  output  LAP_W  completed laps in the current sequence

Behaviour:
- Reset (asynchronous, any time, including mid-sequence): state = IDLE; latched start/end/mode/laps, lap counter, and phase cleared to 0. All outputs 0.
- States: IDLE, LOAD, RUN, DONE (2-bit encoding).
- IDLE: iStart=1 latches iStartValue, iEndValue, iMode, and iLaps (0 -> 1). Clear oLap and phase (phase 0 = outbound). Go to LOAD.
- LOAD: oClear=1, oInitialValue = latched start, oEnable=0. Next state RUN. The counter shows start on the first RUN cycle.
- Direction:
  - dir_up = (end > start), unsigned compare.
  - Outbound (phase 0): oUp_down = dir_up, target = end.
  - Return (phase 1, ping-pong only): oUp_down = ~dir_up, target = start.
  - Counting never crosses 0 or 2^WIDTH-1, so no wrap-around is possible.
- RUN: oEnable = ~iPause & (iCount != target), combinational. When iCount == target, oEnable=0 that same cycle. Transitions on that cycle:
  - single-shot: lap+1; if lap+1 == laps go to DONE, else go to LOAD.
  - ping-pong, phase 0: phase <- 1, stay in RUN (direction flips the next cycle).
  - ping-pong, phase 1: phase <- 0, lap+1; if lap+1 == laps go to DONE, else stay in RUN (counter is already at start, no reload).
- Pause: iPause only gates oEnable. State, phase, and lap are held; target compare still applies.
- Equal start/end: the first RUN cycle matches target. A single-shot lap completes in LOAD+1 cycles. Ping-pong takes 2 RUN cycles per lap.
- DONE: oDone=1 for one cycle, oBusy=1; next state IDLE. oLap keeps its final value until the next iStart.
- Abort: iAbort=1 in LOAD or RUN goes to IDLE next cycle, with no oDone. oEnable and oClear are forced to 0 during the abort cycle. iAbort is ignored in IDLE and DONE.
- Priority within a cycle: reset > abort > target match > pause.
- iStart outside IDLE is ignored. iStart and iAbort together in IDLE: the start is taken.
- Latency, single-shot 1 lap: iStart cycle T; LOAD at T+1; RUN from T+2; DONE at T+3+|end-start| (pause cycles add to this); IDLE the cycle after DONE.
- oInitialValue outside LOAD holds the latched start value (0 after reset).

Test Plan:
- Reset: iReset_n low mid-RUN (start=2, end=9) -> all outputs 0 immediately, asynchronously; next iStart begins a fresh sequence with oLap=0.
- Single-shot up: start=2, end=5, laps=1 -> oClear at T+1, counter 2,3,4,5, oEnable low at count=5, oDone at T+6, oLap=1.
- Single-shot down with repeat: start=9, end=6, laps=2 -> oUp_down=0, two LOAD pulses, counts 9..6 twice, oDone once, oLap=2.
- Ping-pong: start=3, end=5, laps=1 -> counts 3,4,5,4,3; oUp_down 1 then 0; no second LOAD; oDone after count returns to 3.
- Pause and abort: iPause high 3 cycles at count=4 (start=0, end=8) -> count holds at 4 and oDone is delayed by 3 cycles. Repeat the run with iAbort at count=6 -> IDLE next cycle, oDone never asserted, oBusy=0.
- Corner cases: start=end=7 with laps=0 -> exactly 1 lap, oEnable never asserted, oDone at T+3. iStart pulsed while busy -> ignored, latched values unchanged.
